// File: rtl/mdu_if.sv
// Purpose: request/result bundle between the EX stage and the multiply/divide unit.
// Latency: wires only, no storage.
// Backpressure: none here; the EX stage stalls MD-class instructions while start|busy.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// Purpose: MIPS-style HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Latency: MULT_CYCLES or DIV_CYCLES from start edge to HI/LO update; MTHI/MTLO at the start edge.
// Backpressure: busy=1 while an operation is in flight; any start seen while busy is dropped.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  m
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d;

  logic [63:0]     prod_s, prod_u;
  logic [31:0]     a_mag, b_mag, div_s, div_u;
  logic [31:0]     q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Datapath on latched operands: products, and signed divide done on
  // magnitudes so that 0x80000000 / -1 wraps instead of overflowing.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
    // A zero divisor never commits, so substitute 1 to keep the divider defined.
    div_s  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    div_u  = (b_q == 32'd0) ? 32'd1 : b_q;
    q_mag  = a_mag / div_s;
    r_mag  = a_mag % div_s;
    q_s    = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = a_q[31] ? (~r_mag + 32'd1) : r_mag;
    q_u    = a_q / div_u;
    r_u    = a_q % div_u;
  end

  // Next-state: accept work in IDLE, count down in RUN, commit HI/LO on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m.start) begin
          case (m.op)
            OP_MULT, OP_MULTU: begin
              op_d    = m.op;
              a_d     = m.a;
              b_d     = m.b;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = m.op;
              a_d     = m.a;
              b_d     = m.b;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = m.a;
            OP_MTLO: lo_d = m.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV:   if (b_q != 32'd0) begin
                        hi_d = r_s;
                        lo_d = q_s;
                      end
            OP_DIVU:  if (b_q != 32'd0) begin
                        hi_d = r_u;
                        lo_d = q_u;
                      end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign m.busy = (state_q == RUN);
  assign m.done = done_q;
  assign m.hi   = hi_q;
  assign m.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: timing of busy/done, HI/LO results, ignored starts, reset abort.
module tb_mdu;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  mdu_if bus();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .m     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request before a rising edge; return 1 time unit after that edge.
  task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count cycles with busy=1 (bounded) and note any done pulse seen while busy.
  task automatic run_len(output int n, output logic early_done);
    n = 0;
    early_done = 1'b0;
    while (bus.busy && n < 100) begin
      if (bus.done) early_done = 1'b1;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    n_total++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult;
    int n; logic e;
    drive(3'd0, 32'hFFFFFFFE, 32'd3);
    run_len(n, e);
    n_total++;
    if (n !== 5 || e !== 1'b0) $display("FAIL mult_busy: cycles=%0d early_done=%b, want 5 0", n, e);
    else n_pass++;
    n_total++;
    if (bus.done !== 1'b1 || bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA)
      $display("FAIL mult_result: done=%b hi=%h lo=%h, want 1 ffffffff fffffffa", bus.done, bus.hi, bus.lo);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL mult_done_pulse: done=%b, want 0", bus.done);
    else n_pass++;
  endtask

  task automatic test_multu;
    int n; logic e;
    drive(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_len(n, e);
    n_total++;
    if (n !== 5 || bus.done !== 1'b1 || bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001)
      $display("FAIL multu: cycles=%0d done=%b hi=%h lo=%h, want 5 1 fffffffe 00000001", n, bus.done, bus.hi, bus.lo);
    else n_pass++;
  endtask

  task automatic test_div;
    int n; logic e;
    drive(3'd2, 32'hFFFFFFF9, 32'd2);
    run_len(n, e);
    n_total++;
    if (n !== 10 || e !== 1'b0 || bus.done !== 1'b1) $display("FAIL div_busy: cycles=%0d early=%b done=%b, want 10 0 1", n, e, bus.done);
    else n_pass++;
    n_total++;
    if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF)
      $display("FAIL div_result: hi=%h lo=%h, want ffffffff fffffffd", bus.hi, bus.lo);
    else n_pass++;
    drive(3'd3, 32'hFFFFFFF9, 32'd2);
    run_len(n, e);
    n_total++;
    if (n !== 10 || bus.lo !== 32'h7FFFFFFC || bus.hi !== 32'h00000001)
      $display("FAIL divu_result: cycles=%0d hi=%h lo=%h, want 10 00000001 7ffffffc", n, bus.hi, bus.lo);
    else n_pass++;
  endtask

  task automatic test_div_overflow;
    int n; logic e;
    drive(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_len(n, e);
    n_total++;
    if (bus.lo !== 32'h80000000 || bus.hi !== 32'h00000000)
      $display("FAIL div_overflow: hi=%h lo=%h, want 00000000 80000000", bus.hi, bus.lo);
    else n_pass++;
  endtask

  task automatic test_mthi_divzero;
    int n; logic e;
    drive(3'd4, 32'h12345678, 32'd0);
    n_total++;
    if (bus.hi !== 32'h12345678 || bus.lo !== 32'h80000000 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b, want 12345678 80000000 0 0", bus.hi, bus.lo, bus.busy, bus.done);
    else n_pass++;
    drive(3'd2, 32'd55, 32'd0);
    run_len(n, e);
    n_total++;
    if (n !== 10 || bus.done !== 1'b1 || bus.hi !== 32'h12345678 || bus.lo !== 32'h80000000)
      $display("FAIL div_by_zero: cycles=%0d done=%b hi=%h lo=%h, want 10 1 12345678 80000000", n, bus.done, bus.hi, bus.lo);
    else n_pass++;
  endtask

  task automatic test_noop;
    drive(3'd6, 32'hCAFEF00D, 32'd1);
    drive(3'd7, 32'hCAFEF00D, 32'd1);
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h12345678 || bus.lo !== 32'h80000000)
      $display("FAIL noop: busy=%b done=%b hi=%h lo=%h, want 0 0 12345678 80000000", bus.busy, bus.done, bus.hi, bus.lo);
    else n_pass++;
  endtask

  task automatic test_ignore_while_busy;
    int n; logic e;
    drive(3'd0, 32'd7, 32'd6);
    @(posedge clk); #1;
    drive(3'd5, 32'h0000AAAA, 32'd99);
    n_total++;
    if (bus.busy !== 1'b1 || bus.lo !== 32'h80000000 || bus.hi !== 32'h12345678)
      $display("FAIL hold_during_run: busy=%b hi=%h lo=%h, want 1 12345678 80000000", bus.busy, bus.hi, bus.lo);
    else n_pass++;
    bus.op = 3'd3;
    bus.a  = 32'h11111111;
    run_len(n, e);
    n_total++;
    if (n !== 3 || bus.lo !== 32'd42 || bus.hi !== 32'd0)
      $display("FAIL ignore_while_busy: remaining=%0d hi=%h lo=%h, want 3 00000000 0000002a", n, bus.hi, bus.lo);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    drive(3'd1, 32'd3, 32'd5);
    repeat (4) begin @(posedge clk); #1; end
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_last_busy: busy=%b, want 1", bus.busy);
    else n_pass++;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'hDEADBEEF;
    @(posedge clk); #1;
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd15)
      $display("FAIL b2b_edge_ignored: busy=%b done=%b hi=%h lo=%h, want 0 1 00000000 0000000f", bus.busy, bus.done, bus.hi, bus.lo);
    else n_pass++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_total++;
    if (bus.hi !== 32'hDEADBEEF || bus.busy !== 1'b0)
      $display("FAIL b2b_next_accepted: hi=%h busy=%b, want deadbeef 0", bus.hi, bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    logic saw;
    int n; logic e;
    drive(3'd2, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
      $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.lo !== 32'd0) saw = 1'b1;
    end
    n_total++;
    if (saw !== 1'b0) $display("FAIL reset_no_done: activity=%b, want 0", saw);
    else n_pass++;
    drive(3'd0, 32'd2, 32'd3);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL after_reset_accept: busy=%b, want 1", bus.busy);
    else n_pass++;
    run_len(n, e);
    n_total++;
    if (n !== 5 || bus.lo !== 32'd6 || bus.hi !== 32'd0)
      $display("FAIL after_reset_mult: cycles=%0d hi=%h lo=%h, want 5 00000000 00000006", n, bus.hi, bus.lo);
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_overflow();
    test_mthi_divzero();
    test_noop();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
